spis_dma_sequencer: RTL and testbench
=====================================

# spis_dma_sequencer

Sequencer between the SPI slave word stream and the shared dma_writer. Buffers incoming 32-bit words in a small FIFO and cuts them into fixed 32-word blocks. Starts one DMA block transfer per block into a software-configured ring of blocks in main RAM, and advances and wraps the destination pointer. Reports progress, overflow and completion through a CPU register bus.

## Interface
Parameters:
- FIFO_DEPTH, 64: input FIFO depth in words; power of two, at least BLOCK_WORDS.
- BLOCK_WORDS, 32: words per DMA block.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: asynchronous, active-high.
- register_num, input, 3: register select.
- data_in, input, 32: register write data.
- data_out, output, 32: registered read data.
- wen, input, 1: register write strobe.
- ren, input, 1: register read strobe.
- ready, output, 1: bus access acknowledge.
- in_data, input, 32: word from the SPI slave.
- in_strobe, input, 1: in_data is valid this cycle.
- in_frame_end, input, 1: single-cycle pulse when CS deasserts.
- dma_addr, output, 32: block destination byte address.
- dma_len, output, 16: block length in words, constant BLOCK_WORDS.
- dma_run, output, 1: single-cycle pulse that starts a block.
- dma_ready, input, 1: writer can accept a word this cycle.
- dma_strobe, output, 1: dma_data is valid and is consumed this cycle.
- dma_data, output, 32: word to the writer.
- dma_done, input, 1: writer has committed the block.
- irq, output, 1: level interrupt.

## Operation
Registers:
- 0 CTRL/STAT: bit0 enable (r/w); bit1 busy (ro, FSM not IDLE); bit2 overflow (sticky, write 1 to clear); bit3 block_irq (sticky, write 1 to clear); bit4 short_frame (sticky, write 1 to clear).
- 1 BASE: ring base byte address. Bits [1:0] are forced to 0.
- 2 SIZE: ring size in blocks, bits [15:0]. A value of 0 is treated as 1.
- 3 WPTR: current block index, read-only.
- 4 COUNT: completed blocks, 32-bit, wraps, read-only.
- Any other register reads 0; writes to it are ignored.

Input side:
- Words are pushed only while enable=1. While disabled, words are dropped silently.
- in_strobe with the FIFO full: the word is dropped and overflow is set.

Pointer and address:
- WPTR and COUNT clear on an enable 0→1 edge.
- dma_addr = BASE + WPTR*BLOCK_WORDS*4. It is latched in START.
- ADVANCE: WPTR = (WPTR+1 == SIZE) ? 0 : WPTR+1. COUNT increments.

FSM states:
- IDLE: go to START when enable=1 and the FIFO holds at least BLOCK_WORDS words, or when enable=1, in_frame_end was seen and the FIFO is not empty.
- START: pulse dma_run; clear the sent counter; go to STREAM.
- STREAM: each cycle with dma_ready and the FIFO not empty, pop a word and assert dma_strobe. Go to WAIT_DONE after BLOCK_WORDS words. If the FIFO is empty with a pending frame end, go to PAD.
- PAD: emit zero words with dma_strobe on dma_ready until BLOCK_WORDS words are sent; set short_frame; go to WAIT_DONE.
- WAIT_DONE: wait for dma_done; go to ADVANCE.
- ADVANCE: update the pointer, set block_irq, go to IDLE.

Boundary conditions:
- Frame end pending: a latch set by in_frame_end and cleared when the PAD decision is taken or a block ends with the FIFO empty.
- Clearing enable mid-block: the current block completes through ADVANCE, then the FSM idles. The FIFO is then flushed.
- BASE or SIZE written while busy: takes effect at the next START or ADVANCE.
- A W1C clear and a set of the same bit in one cycle: the set wins.
- Push and pop in the same cycle on a full FIFO: the push is accepted.

## Timing
- ready asserts the cycle after wen or ren, for 1 cycle. data_out is valid with ready.
- Reset values: all outputs 0, except dma_len = BLOCK_WORDS. Registers reset to 0; FSM to IDLE; FIFO empty.
- Reset asserted mid-operation aborts immediately; the writer is expected to be reset together with this block.
- Latency: the BLOCK_WORDS-th push at cycle t gives dma_run at t+2. The first dma_strobe comes no earlier than t+3.
- dma_data comes straight from the FIFO head with no extra stage. The stream runs at 1 word per cycle while dma_ready stays high.

## Configuration
- SPIS_SEQ_IRQ_EN defined: irq = enable & (block_irq | overflow).
- SPIS_SEQ_IRQ_EN undefined: irq is tied 0 and bit3 reads 0. The block_irq logic is removed; overflow is unaffected.

## Structure
- Package spis_seq_pkg holds:
  - register index constants (REG_CTRL=0 … REG_COUNT=4);
  - CTRL bit positions;
  - the FSM state enum (IDLE, START, STREAM, PAD, WAIT_DONE, ADVANCE);
  - the default BLOCK_WORDS.
- Sub-module spis_seq_fifo: synchronous FIFO, first-word-fall-through, with count output. Parameterised by FIFO_DEPTH.

## Test plan
- BASE=0x1000, SIZE=2, enable, 96 words → dma_run three times at 0x1000, 0x1080, 0x1000. WPTR ends at 1, COUNT=3.
- 40 words, then in_frame_end → block 1 holds words 0-31. Block 2 holds words 32-39 plus 24 zero words. short_frame=1.
- dma_ready held low while 70 words arrive → overflow=1 and exactly 6 words are dropped. A write of 0x4 to CTRL clears overflow.
- Enable cleared after 10 words of a running block → that block completes with dma_done, FSM returns to IDLE, FIFO is flushed, busy reads 0.
- Reset asserted in STREAM → all outputs 0 immediately and COUNT=0. A new 32-word stream after release transfers cleanly to BASE.
- With SPIS_SEQ_IRQ_EN, complete one block → irq=1. A write of 0x8 to CTRL drops irq to 0. With the macro undefined, irq stays 0.

Source files
------------

// File: rtl/spis_seq_pkg.sv
// spis_seq_pkg: register map, CTRL bit positions and FSM states shared by the SPI-slave DMA sequencer.
package spis_seq_pkg;
    localparam int BLOCK_WORDS_DEF = 32;
    localparam logic [2:0] REG_CTRL  = 3'd0;
    localparam logic [2:0] REG_BASE  = 3'd1;
    localparam logic [2:0] REG_SIZE  = 3'd2;
    localparam logic [2:0] REG_WPTR  = 3'd3;
    localparam logic [2:0] REG_COUNT = 3'd4;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_OVF   = 2;
    localparam int CTRL_BIRQ  = 3;
    localparam int CTRL_SHORT = 4;
    typedef enum logic [2:0] {IDLE, START, STREAM, PAD, WAIT_DONE, ADVANCE} state_t;
endpackage

// File: rtl/spis_seq_fifo.sv
// spis_seq_fifo: first-word-fall-through synchronous FIFO with occupancy count and flush.
module spis_seq_fifo #(
    parameter int FIFO_DEPTH = 64,
    parameter int AW = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop & !empty;
    // a pop frees the slot the simultaneous push lands in
    assign do_push = push & (!full | do_pop);
    assign rdata   = mem[rp];
    always_ff @(posedge clk)
        if (do_push && !flush)
            mem[wp] <= wdata;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= do_push ? wp + AW'(1) : wp;
            rp    <= do_pop ? rp + AW'(1) : rp;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/spis_dma_sequencer.sv
// spis_dma_sequencer: buffers SPI slave words and streams them as fixed-size DMA blocks into a RAM ring.
// Define SPIS_SEQ_IRQ_EN to build the block_irq flag and the irq output.
module spis_dma_sequencer
    import spis_seq_pkg::*;
#(
    parameter int FIFO_DEPTH  = 64,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  register_num,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        wen,
    input  logic        ren,
    output logic        ready,
    input  logic [31:0] in_data,
    input  logic        in_strobe,
    input  logic        in_frame_end,
    output logic [31:0] dma_addr,
    output logic [15:0] dma_len,
    output logic        dma_run,
    input  logic        dma_ready,
    output logic        dma_strobe,
    output logic [31:0] dma_data,
    input  logic        dma_done,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(BLOCK_WORDS) + 1;
    localparam logic [31:0] BLOCK_BYTES = 32'(BLOCK_WORDS * 4);
    state_t state;
    logic enable, overflow, block_irq, short_frame, fe_pend;
    logic [31:0] base, count_r, fdata, rd;
    logic [15:0] size, wptr, size_eff, wptr_inc;
    logic [AW:0] fcount;
    logic [SW-1:0] sent;
    logic ffull, fempty, busy, flush, push, pop, ctrl_wr, en_rise;
    logic start_ok, pad_go, block_end, fe_clr;
    assign size_eff   = size == '0 ? 16'd1 : size;
    assign wptr_inc   = wptr + 16'd1;
    assign busy       = state != IDLE;
    // after a disable the FIFO is only dropped once the in-flight block has finished
    assign flush      = !enable & !busy;
    assign push       = in_strobe & enable;
    assign pop        = state == STREAM & dma_ready & !fempty;
    assign dma_strobe = pop | (state == PAD & dma_ready);
    assign dma_data   = state == STREAM ? fdata : '0;
    assign dma_len    = 16'(BLOCK_WORDS);
    assign ctrl_wr    = wen & register_num == REG_CTRL;
    assign en_rise    = ctrl_wr & data_in[CTRL_EN] & !enable;
    assign start_ok   = enable & (fcount >= (AW+1)'(BLOCK_WORDS) | fe_pend & !fempty);
    // a disabled stream that runs dry is padded so the block still completes
    assign pad_go     = state == STREAM & fempty & (fe_pend | !enable);
    assign block_end  = dma_strobe & sent == SW'(BLOCK_WORDS - 1);
    assign fe_clr     = pad_go | (state == ADVANCE & fempty);
    assign rd = register_num == REG_CTRL  ? {27'd0, short_frame, block_irq, overflow, busy, enable} :
                register_num == REG_BASE  ? base :
                register_num == REG_SIZE  ? {16'd0, size} :
                register_num == REG_WPTR  ? {16'd0, wptr} :
                register_num == REG_COUNT ? count_r : '0;
    spis_seq_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .flush(flush), .push(push), .pop(pop), .wdata(in_data),
        .rdata(fdata), .count(fcount), .full(ffull), .empty(fempty)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ready       <= 1'b0;
            data_out    <= '0;
            enable      <= 1'b0;
            base        <= '0;
            size        <= '0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
            fe_pend     <= 1'b0;
        end else begin
            ready       <= wen | ren;
            data_out    <= ren ? rd : '0;
            enable      <= ctrl_wr ? data_in[CTRL_EN] : enable;
            base        <= wen && register_num == REG_BASE ? {data_in[31:2], 2'b00} : base;
            size        <= wen && register_num == REG_SIZE ? data_in[15:0] : size;
            overflow    <= (push & ffull & !pop) | overflow & !(ctrl_wr & data_in[CTRL_OVF]);
            short_frame <= pad_go | short_frame & !(ctrl_wr & data_in[CTRL_SHORT]);
            fe_pend     <= !flush & (in_frame_end | fe_pend & !fe_clr);
        end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= IDLE;
            dma_run  <= 1'b0;
            dma_addr <= '0;
            sent     <= '0;
            wptr     <= '0;
            count_r  <= '0;
        end else begin
            dma_run <= 1'b0;
            case (state)
                IDLE: if (start_ok) begin
                    state    <= START;
                    dma_run  <= 1'b1;
                    dma_addr <= base + {16'd0, wptr} * BLOCK_BYTES;
                end
                START: begin
                    sent  <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    sent  <= dma_strobe ? sent + SW'(1) : sent;
                    state <= block_end ? WAIT_DONE : pad_go ? PAD : STREAM;
                end
                PAD: begin
                    sent  <= dma_strobe ? sent + SW'(1) : sent;
                    state <= block_end ? WAIT_DONE : PAD;
                end
                WAIT_DONE: state <= dma_done ? ADVANCE : WAIT_DONE;
                ADVANCE: begin
                    wptr    <= wptr_inc >= size_eff ? '0 : wptr_inc;
                    count_r <= count_r + 32'd1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (en_rise) begin
                wptr    <= '0;
                count_r <= '0;
            end
        end
`ifdef SPIS_SEQ_IRQ_EN
    always_ff @(posedge clk or posedge reset)
        if (reset)
            block_irq <= 1'b0;
        else
            block_irq <= (state == ADVANCE) | block_irq & !(ctrl_wr & data_in[CTRL_BIRQ]);
    assign irq = enable & (block_irq | overflow);
`else
    assign block_irq = 1'b0;
    assign irq       = 1'b0;
`endif
endmodule

// File: tb/tb_spis_dma_sequencer.sv
// tb_spis_dma_sequencer: directed scenarios for the SPI-slave DMA sequencer with a writer model answering dma_done.
module tb_spis_dma_sequencer;
    import spis_seq_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] register_num = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic wen = 1'b0, ren = 1'b0, ready;
    logic [31:0] in_data = '0;
    logic in_strobe = 1'b0, in_frame_end = 1'b0;
    logic [31:0] dma_addr, dma_data;
    logic [15:0] dma_len;
    logic dma_run, dma_strobe, irq;
    logic dma_ready = 1'b1;
    logic dma_done = 1'b0;
    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] runs_q[$];
    logic [31:0] data_q[$];
    int run_cyc_q[$];
    int first_q[$];
    int blk_words = 0;
    bit done_pend = 0;

    spis_dma_sequencer dut (
        .clk(clk), .reset(reset), .register_num(register_num), .data_in(data_in), .data_out(data_out),
        .wen(wen), .ren(ren), .ready(ready), .in_data(in_data), .in_strobe(in_strobe),
        .in_frame_end(in_frame_end), .dma_addr(dma_addr), .dma_len(dma_len), .dma_run(dma_run),
        .dma_ready(dma_ready), .dma_strobe(dma_strobe), .dma_data(dma_data), .dma_done(dma_done), .irq(irq)
    );

    always #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;

    // writer model: records runs and words, pulses dma_done one cycle after the 32nd word
    initial forever begin
        @(negedge clk);
        dma_done = done_pend;
        done_pend = 0;
        if (dma_run) begin
            runs_q.push_back(dma_addr);
            run_cyc_q.push_back(cyc);
            blk_words = 0;
        end
        if (dma_strobe) begin
            if (blk_words == 0) first_q.push_back(cyc);
            data_q.push_back(dma_data);
            blk_words++;
            if (blk_words == 32) done_pend = 1;
        end
    end

    task automatic clear_log();
        runs_q.delete();
        data_q.delete();
        run_cyc_q.delete();
        first_q.delete();
    endtask

    task automatic reg_write(input logic [2:0] n, input logic [31:0] d);
        @(posedge clk); #1;
        register_num = n; data_in = d; wen = 1'b1;
        @(posedge clk); #1;
        wen = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] n, output logic [31:0] d);
        @(posedge clk); #1;
        register_num = n; ren = 1'b1;
        @(posedge clk); #1;
        ren = 1'b0;
        d = data_out;
    endtask

    task automatic push_words(input int n, input logic [31:0] v, output int t_last);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_data = v + 32'(i); in_strobe = 1'b1; t_last = cyc;
        end
        @(posedge clk); #1;
        in_strobe = 1'b0;
    endtask

    task automatic frame_end();
        @(posedge clk); #1; in_frame_end = 1'b1;
        @(posedge clk); #1; in_frame_end = 1'b0;
    endtask

    task automatic wait_idle(input int nruns, input string name);
        logic [31:0] r;
        int k;
        for (k = 0; k < 1000; k++) begin
            reg_read(REG_CTRL, r);
            if (runs_q.size() >= nruns && !r[CTRL_BUSY]) break;
        end
        vectors++;
        if (k == 1000) begin
            errors++;
            $display("FAIL %s_idle: timed out, runs=%0d required %0d", name, runs_q.size(), nruns);
        end
    endtask

    task automatic restart(input int t_dummy);
        reg_write(REG_CTRL, 32'h0);
        reg_write(REG_CTRL, 32'h1);
        clear_log();
    endtask

    task automatic test_reset();
        logic [31:0] r;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({dma_run, dma_strobe, irq, ready} !== 4'b0 || dma_addr !== 32'h0 || data_out !== 32'h0 || dma_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: run/strobe/irq/ready=%b addr=%h dout=%h ddata=%h required all 0",
                     {dma_run, dma_strobe, irq, ready}, dma_addr, data_out, dma_data);
        end
        vectors++;
        if (dma_len !== 16'd32) begin errors++; $display("FAIL reset_len: got %0d required 32", dma_len); end
        reset = 1'b0;
        reg_read(REG_CTRL, r);
        vectors++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h required 0", r); end
        vectors++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ready_pulse: got %b required 1", ready); end
        @(posedge clk); #1;
        vectors++;
        if (ready !== 1'b0) begin errors++; $display("FAIL ready_drop: got %b required 0", ready); end
        reg_read(REG_COUNT, r);
        vectors++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_count: got %h required 0", r); end
    endtask

    task automatic test_ring();
        logic [31:0] r;
        int t, bad;
        reg_write(REG_BASE, 32'h1003);
        reg_read(REG_BASE, r);
        vectors++;
        if (r !== 32'h1000) begin errors++; $display("FAIL base_align: got %h required 00001000", r); end
        reg_write(REG_SIZE, 32'd2);
        reg_write(REG_CTRL, 32'h1);
        clear_log();
        push_words(32, 32'h100, t);
        push_words(64, 32'h120, t);
        wait_idle(3, "ring");
        vectors++;
        if (run_cyc_q.size() < 1 || run_cyc_q[0] != t - 64 - 1 + 2) begin
            // first 32-word call ended one idle cycle plus 64 pushes before t
            errors++;
            $display("FAIL run_latency: got cycle %0d required %0d", run_cyc_q.size() ? run_cyc_q[0] : -1, t - 63 + 2 - 2);
        end
        vectors++;
        if (first_q.size() < 1 || first_q[0] < t - 65 + 3) begin
            errors++; $display("FAIL strobe_latency: got cycle %0d required >= %0d", first_q.size() ? first_q[0] : -1, t - 62);
        end
        vectors++;
        if (runs_q.size() != 3 || runs_q[0] !== 32'h1000 || runs_q[1] !== 32'h1080 || runs_q[2] !== 32'h1000) begin
            errors++;
            $display("FAIL ring_addrs: got n=%0d %h %h %h required 3 00001000 00001080 00001000", runs_q.size(),
                     runs_q.size() > 0 ? runs_q[0] : 0, runs_q.size() > 1 ? runs_q[1] : 0, runs_q.size() > 2 ? runs_q[2] : 0);
        end
        bad = 0;
        foreach (data_q[i]) if (data_q[i] !== 32'h100 + 32'(i)) bad++;
        vectors++;
        if (data_q.size() != 96 || bad != 0) begin
            errors++; $display("FAIL ring_data: got %0d words %0d wrong required 96 words 0 wrong", data_q.size(), bad);
        end
        reg_read(REG_WPTR, r);
        vectors++;
        if (r !== 32'd1) begin errors++; $display("FAIL ring_wptr: got %0d required 1", r); end
        reg_read(REG_COUNT, r);
        vectors++;
        if (r !== 32'd3) begin errors++; $display("FAIL ring_count: got %0d required 3", r); end
    endtask

    task automatic test_short_frame();
        logic [31:0] r;
        int t, bad;
        restart(0);
        push_words(40, 32'h200, t);
        frame_end();
        wait_idle(2, "short");
        vectors++;
        if (runs_q.size() != 2 || runs_q[0] !== 32'h1000 || runs_q[1] !== 32'h1080) begin
            errors++; $display("FAIL short_addrs: got n=%0d required 2 at 00001000 00001080", runs_q.size());
        end
        bad = 0;
        foreach (data_q[i]) if (data_q[i] !== (i < 40 ? 32'h200 + 32'(i) : 32'h0)) bad++;
        vectors++;
        if (data_q.size() != 64 || bad != 0) begin
            errors++; $display("FAIL short_data: got %0d words %0d wrong required 64 words 0 wrong", data_q.size(), bad);
        end
        reg_read(REG_CTRL, r);
        vectors++;
        if (r[CTRL_SHORT] !== 1'b1) begin errors++; $display("FAIL short_flag: got %b required 1", r[CTRL_SHORT]); end
        reg_write(REG_CTRL, 32'h11);
        reg_read(REG_CTRL, r);
        vectors++;
        if (r[CTRL_SHORT] !== 1'b0 || r[CTRL_EN] !== 1'b1) begin
            errors++; $display("FAIL short_w1c: got short=%b en=%b required short=0 en=1", r[CTRL_SHORT], r[CTRL_EN]);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        int t;
        restart(0);
        dma_ready = 1'b0;
        push_words(70, 32'h300, t);
        reg_read(REG_CTRL, r);
        vectors++;
        if (r[CTRL_OVF] !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", r[CTRL_OVF]); end
        reg_write(REG_CTRL, 32'h5);
        reg_read(REG_CTRL, r);
        vectors++;
        if (r[CTRL_OVF] !== 1'b0 || r[CTRL_EN] !== 1'b1) begin
            errors++; $display("FAIL ovf_w1c: got ovf=%b en=%b required ovf=0 en=1", r[CTRL_OVF], r[CTRL_EN]);
        end
        dma_ready = 1'b1;
        wait_idle(2, "ovf");
        repeat (50) @(posedge clk);
        vectors++;
        if (runs_q.size() != 2 || data_q.size() != 64) begin
            errors++; $display("FAIL ovf_kept: got runs=%0d words=%0d required runs=2 words=64", runs_q.size(), data_q.size());
        end
        vectors++;
        if (data_q.size() != 64 || data_q[32] !== 32'h320 || data_q[63] !== 32'h33f) begin
            errors++; $display("FAIL ovf_order: words 32/63 wrong required 00000320 0000033f");
        end
    endtask

    task automatic test_disable_mid_block();
        logic [31:0] r;
        int t;
        restart(0);
        dma_ready = 1'b0;
        push_words(40, 32'h400, t);
        @(posedge clk); #1; dma_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1; dma_ready = 1'b0;
        vectors++;
        if (data_q.size() != 10) begin errors++; $display("FAIL dis_partial: got %0d words required 10", data_q.size()); end
        reg_write(REG_CTRL, 32'h0);
        dma_ready = 1'b1;
        wait_idle(1, "dis");
        vectors++;
        if (data_q.size() != 32 || data_q[31] !== 32'h41f) begin
            errors++; $display("FAIL dis_complete: got %0d words required 32 ending 0000041f", data_q.size());
        end
        reg_read(REG_CTRL, r);
        vectors++;
        if (r[CTRL_BUSY] !== 1'b0) begin errors++; $display("FAIL dis_busy: got %b required 0", r[CTRL_BUSY]); end
        repeat (5) @(posedge clk);
        reg_write(REG_CTRL, 32'h1);
        repeat (40) @(posedge clk);
        vectors++;
        if (runs_q.size() != 1) begin errors++; $display("FAIL dis_flush: got %0d runs required 1", runs_q.size()); end
        push_words(32, 32'h480, t);
        wait_idle(2, "dis2");
        vectors++;
        if (data_q.size() != 64 || data_q[32] !== 32'h480) begin
            errors++; $display("FAIL dis_fresh: got %0d words, word32 wrong required 64 with 00000480", data_q.size());
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [31:0] r;
        int t;
        restart(0);
        push_words(32, 32'h500, t);
        wait_idle(1, "rst1");
        dma_ready = 1'b0;
        push_words(32, 32'h520, t);
        repeat (4) @(posedge clk);
        reg_read(REG_COUNT, r);
        vectors++;
        if (r !== 32'd1) begin errors++; $display("FAIL rst_precount: got %0d required 1", r); end
        @(posedge clk); #1;
        dma_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({dma_run, dma_strobe, irq, ready} !== 4'b0 || dma_addr !== 32'h0 || dma_data !== 32'h0) begin
            errors++; $display("FAIL rst_mid_outputs: run/strobe/irq/ready=%b addr=%h data=%h required all 0",
                               {dma_run, dma_strobe, irq, ready}, dma_addr, dma_data);
        end
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        reg_read(REG_COUNT, r);
        vectors++;
        if (r !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d required 0", r); end
        reg_write(REG_BASE, 32'h4000);
        reg_write(REG_SIZE, 32'd2);
        reg_write(REG_CTRL, 32'h1);
        clear_log();
        push_words(32, 32'h600, t);
        wait_idle(1, "rst2");
        vectors++;
        if (runs_q.size() != 1 || runs_q[0] !== 32'h4000 || data_q.size() != 32 || data_q[0] !== 32'h600 || data_q[31] !== 32'h61f) begin
            errors++; $display("FAIL rst_restart: got runs=%0d words=%0d required 1 run at 00004000 with 00000600..0000061f",
                               runs_q.size(), data_q.size());
        end
    endtask

    task automatic test_irq();
        logic [31:0] r;
        int t;
        reg_write(REG_CTRL, 32'h9);
        clear_log();
`ifdef SPIS_SEQ_IRQ_EN
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b required 0", irq); end
        push_words(32, 32'h700, t);
        wait_idle(1, "irq");
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b required 1", irq); end
        reg_write(REG_CTRL, 32'h9);
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b required 0", irq); end
`else
        push_words(32, 32'h700, t);
        wait_idle(1, "irq");
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied: got %b required 0", irq); end
        reg_read(REG_CTRL, r);
        vectors++;
        if (r[CTRL_BIRQ] !== 1'b0) begin errors++; $display("FAIL birq_absent: got %b required 0", r[CTRL_BIRQ]); end
`endif
    endtask

    initial begin
        test_reset();
        test_ring();
        test_short_frame();
        test_overflow();
        test_disable_mid_block();
        test_reset_mid_stream();
        test_irq();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
